fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one outstanding imem request at a time, buffers
// a response that arrives while decode is stalled, and discards responses made stale by a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jal_flush,
  input  logic        branch_flush,
  input  logic [31:0] jal_target,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;

  logic        flush;
  logic [31:0] redirect_pc;
  logic        grant;

  assign flush       = jal_flush | branch_flush;
  // The branch comes from an older instruction than the jal, so it wins.
  assign redirect_pc = branch_flush ? branch_target : jal_target;

  assign imem_req  = (state_q == S_REQ) && !rst;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;
  assign inst      = inst_q;
  assign pc        = pc_q;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    inst_d      = inst_q;
    pc_d        = pc_q;

    unique case (state_q)
      S_REQ: begin
        if (grant) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          // A request granted alongside a redirect fetches the wrong path.
          state_d    = flush ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (!flush && stall) begin
            hold_inst_d = imem_rdata;
            hold_pc_d   = req_pc_q;
            state_d     = S_HOLD;
          end else begin
            state_d = S_REQ;
          end
        end else if (flush) begin
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (flush || !stall) state_d = S_REQ;
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (flush) begin
      inst_d     = NOP_INST;
      pc_d       = redirect_pc;
      fetch_pc_d = redirect_pc;
    end else if (!stall) begin
      if (state_q == S_HOLD) begin
        inst_d = hold_inst_q;
        pc_d   = hold_pc_q;
      end else if (state_q == S_WAIT && imem_rvalid) begin
        inst_d = imem_rdata;
        pc_d   = req_pc_q;
      end else begin
        inst_d = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      inst_q     <= NOP_INST;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
    end
  end

  // Request PC and stall buffer are qualified by the state, so they need no reset.
  always_ff @(posedge clk) begin
    req_pc_q    <= req_pc_d;
    hold_inst_q <= hold_inst_d;
    hold_pc_q   <= hold_pc_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small single-outstanding memory model driven
// cycle by cycle, with hand-computed inst/pc/imem_addr expectations.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, jal_flush, branch_flush;
  logic [31:0] jal_target, branch_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata, inst, pc;

  int checks = 0;
  int errors = 0;

  logic        gnt_en, delay_resp, pend, acc;
  logic [31:0] pend_addr, acc_addr;

  fetch_unit #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jal_flush(jal_flush),
    .branch_flush(branch_flush), .jal_target(jal_target),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00500093;
      32'h8:   return 32'h00208133;
      default: return a ^ 32'hA5A50000;
    endcase
  endfunction

  // One clock of the memory model: rvalid one cycle after grant unless delayed.
  task automatic step();
    imem_rvalid = pend && !delay_resp;
    imem_rdata  = mem_word(pend_addr);
    imem_gnt    = gnt_en;
    #1;
    acc      = imem_req && imem_gnt;
    acc_addr = imem_addr;
    @(posedge clk);
    #1;
    pend      = acc | (pend & delay_resp);
    if (acc) pend_addr = acc_addr;
    imem_rvalid = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic [31:0] ei, input logic [31:0] ep);
    checks++;
    if (inst !== ei) begin errors++; $display("FAIL %s inst: got %h want %h", nm, inst, ei); end
    checks++;
    if (pc !== ep) begin errors++; $display("FAIL %s pc: got %h want %h", nm, pc, ep); end
  endtask

  task automatic chk_req(input string nm, input logic er, input logic [31:0] ea);
    checks++;
    if (imem_req !== er) begin errors++; $display("FAIL %s imem_req: got %b want %b", nm, imem_req, er); end
    if (er) begin
      checks++;
      if (imem_addr !== ea) begin errors++; $display("FAIL %s imem_addr: got %h want %h", nm, imem_addr, ea); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; gnt_en = 1'b0;
    step(); step();
    chk_req("reset_req_low", 1'b0, 32'h0);
    chk_out("reset_out", NOP, 32'h0);
    rst = 1'b0;
    #1;
    chk_req("reset_release", 1'b1, 32'h0);
  endtask

  task automatic test_basic();
    gnt_en = 1'b1;
    step();
    chk_req("basic_wait", 1'b0, 32'h0);
    step();
    chk_out("basic_first", 32'h00500093, 32'h0);
    chk_req("basic_next", 1'b1, 32'h4);
    step();
    chk_out("basic_bubble", NOP, 32'h0);
    step();
    chk_out("basic_second", 32'hA5A50004, 32'h4);
  endtask

  task automatic test_stall();
    step();
    chk_out("stall_pre", NOP, 32'h4);
    stall = 1'b1;
    step();
    chk_out("stall_held", NOP, 32'h4);
    chk_req("stall_hold_req", 1'b0, 32'h0);
    step();
    chk_out("stall_held2", NOP, 32'h4);
    stall = 1'b0;
    step();
    chk_out("stall_release", 32'h00208133, 32'h8);
    chk_req("stall_next", 1'b1, 32'hC);
  endtask

  task automatic test_flush_wait();
    step();
    delay_resp = 1'b1; branch_flush = 1'b1; branch_target = 32'h40;
    step();
    branch_flush = 1'b0;
    chk_out("flushw_nop", NOP, 32'h40);
    chk_req("flushw_drop", 1'b0, 32'h0);
    delay_resp = 1'b0;
    step();
    chk_out("flushw_discard", NOP, 32'h40);
    chk_req("flushw_refetch", 1'b1, 32'h40);
    step(); step();
    chk_out("flushw_new", 32'hA5A50040, 32'h40);
  endtask

  task automatic test_dual_flush();
    gnt_en = 1'b0;
    jal_flush = 1'b1; jal_target = 32'h100;
    branch_flush = 1'b1; branch_target = 32'h200;
    step();
    jal_flush = 1'b0; branch_flush = 1'b0;
    chk_req("dual_addr", 1'b1, 32'h200);
    chk_out("dual_out", NOP, 32'h200);
    gnt_en = 1'b1; jal_flush = 1'b1; jal_target = 32'h300;
    step();
    jal_flush = 1'b0;
    chk_req("jal_gnt_stale", 1'b0, 32'h0);
    chk_out("jal_out", NOP, 32'h300);
    step();
    chk_req("jal_refetch", 1'b1, 32'h300);
    chk_out("jal_discard", NOP, 32'h300);
  endtask

  task automatic test_wrap();
    gnt_en = 1'b0; branch_flush = 1'b1; branch_target = 32'hFFFFFFFC;
    step();
    branch_flush = 1'b0;
    chk_req("wrap_addr", 1'b1, 32'hFFFFFFFC);
    gnt_en = 1'b1;
    step(); step();
    chk_out("wrap_inst", 32'h5A5AFFFC, 32'hFFFFFFFC);
    chk_req("wrap_next", 1'b1, 32'h0);
  endtask

  task automatic test_gnt_low();
    gnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_req("gntlow_req", 1'b1, 32'h0);
      chk_out("gntlow_out", NOP, 32'hFFFFFFFC);
    end
    gnt_en = 1'b1;
    step(); step();
    chk_out("gntlow_after", 32'h00500093, 32'h0);
  endtask

  task automatic test_flush_hold();
    step();
    stall = 1'b1;
    step();
    chk_req("fhold_in_hold", 1'b0, 32'h0);
    branch_flush = 1'b1; branch_target = 32'h80;
    step();
    branch_flush = 1'b0; stall = 1'b0;
    chk_out("fhold_flush", NOP, 32'h80);
    chk_req("fhold_req", 1'b1, 32'h80);
    step();
    chk_out("fhold_cleared", NOP, 32'h80);
  endtask

  task automatic test_reset_outstanding();
    rst = 1'b1; delay_resp = 1'b1;
    #1;
    chk_req("rsto_req_low", 1'b0, 32'h0);
    step();
    chk_out("rsto_reset", NOP, 32'h0);
    rst = 1'b0; delay_resp = 1'b0; gnt_en = 1'b0;
    step();
    chk_out("rsto_ignored", NOP, 32'h0);
    chk_req("rsto_req", 1'b1, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jal_flush = 1'b0; branch_flush = 1'b0;
    jal_target = '0; branch_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    gnt_en = 1'b0; delay_resp = 1'b0; pend = 1'b0; pend_addr = '0;
    acc = 1'b0; acc_addr = '0;
    test_reset();
    test_basic();
    test_stall();
    test_flush_wait();
    test_dual_flush();
    test_wrap();
    test_gnt_low();
    test_flush_hold();
    test_reset_outstanding();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
